// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg: op encoding and widths shared by the multiply issue/result stages.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_pkg;

  localparam int XLEN   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

endpackage

`default_nettype wire

// File: rtl/mul_sign_corr.sv
// ---------------------------------------------------------------------------
// mul_sign_corr: high-word correction turning an unsigned product into a signed one.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_sign_corr
  import mul_pkg::*;
(
  input  mul_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] corr_o
);

  // A negative operand read as unsigned adds 2^32 * (other operand) to the
  // product, so its high word is over by exactly that other operand.
  always_comb begin
    corr_o = '0;
    case (op_i)
      MULH:    corr_o = (a_i[XLEN-1] ? b_i : '0) + (b_i[XLEN-1] ? a_i : '0);
      MULHSU:  corr_o =  a_i[XLEN-1] ? b_i : '0;
      default: corr_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mul_result_stage.sv
// ---------------------------------------------------------------------------
// mul_result_stage: two-stage valid/ready pipe producing MUL/MULH/MULHSU/MULHU results.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_result_stage
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  mul_op_e           in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [PROD_W-1:0] in_product,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]  out_tag
);

  logic              v1_q;
  mul_op_e           op1_q;
  logic [TAG_W-1:0]  tag1_q;
  logic [XLEN-1:0]   lo1_q;
  logic [XLEN-1:0]   hi1_q;
  logic [XLEN-1:0]   corr1_q;
  logic              v2_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag2_q;

  logic              adv1;
  logic              adv2;
  logic [XLEN-1:0]   corr_d;
  logic [XLEN-1:0]   result_d;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  mul_sign_corr u_sign_corr (
    .op_i   (in_op),
    .a_i    (in_a),
    .b_i    (in_b),
    .corr_o (corr_d)
  );

  assign result_d = (op1_q == MUL) ? lo1_q : (hi1_q - corr1_q);

  // Payloads load only alongside a valid so bubbles keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      op1_q    <= MUL;
      tag1_q   <= '0;
      lo1_q    <= '0;
      hi1_q    <= '0;
      corr1_q  <= '0;
      v2_q     <= 1'b0;
      result_q <= '0;
      tag2_q   <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          op1_q   <= in_op;
          tag1_q  <= in_tag;
          lo1_q   <= in_product[XLEN-1:0];
          hi1_q   <= in_product[PROD_W-1:XLEN];
          corr1_q <= corr_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          result_q <= result_d;
          tag2_q   <= tag1_q;
        end
      end
    end
  end

  assign out_valid  = v2_q;
  assign out_result = result_q;
  assign out_tag    = tag2_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_result_stage.sv
// ---------------------------------------------------------------------------
// tb_mul_result_stage: directed and randomized checks against a signed-arithmetic model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_result_stage;
  import mul_pkg::*;

  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  mul_op_e           in_op;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [63:0]       in_product;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;

  mul_result_stage #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_product (in_product),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_out    = 0;

  logic             acc, o_fire, o_valid;
  logic [31:0]      o_res;
  logic [TAG_W-1:0] o_tag;
  logic             hold_pending = 1'b0;
  logic [31:0]      hold_res;
  logic [TAG_W-1:0] hold_tag;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: true signed/unsigned 64-bit product, pick the requested word.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at negedge, sample just after, book the handshakes that
  // will happen on the coming posedge.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic rdy);
    exp_t e;
    @(negedge clk);
    in_valid   = v;
    in_op      = mul_op_e'(op);
    in_a       = a;
    in_b       = b;
    in_product = {32'b0, a} * {32'b0, b};
    in_tag     = tag;
    out_ready  = rdy;
    #1;
    acc     = in_valid && in_ready;
    o_fire  = out_valid && out_ready;
    o_valid = out_valid;
    o_res   = out_result;
    o_tag   = out_tag;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, hold_res);
        check("hold_tag", out_tag, hold_tag);
      end
      hold_pending = out_valid && !out_ready;
      hold_res     = out_result;
      hold_tag     = out_tag;
      if (o_fire) begin
        if (q.size() == 0) begin
          check("spurious_out", o_fire, 0);
        end else begin
          e = q.pop_front();
          check("result", out_result, e.res);
          check("tag", out_tag, e.tag);
          n_out++;
        end
      end
      if (acc) q.push_back('{ref_res(op, a, b), tag});
    end
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp);
    step(1'b1, op, a, b, tag, 1'b1);
    check({name, "_accept"}, acc, 1);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check({name, "_lat1"}, o_valid, 0);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check({name, "_valid"}, o_valid, 1);
    check({name, "_res"}, o_res, exp);
    check({name, "_tag"}, o_tag, tag);
  endtask

  logic [1:0]  bp_op[4];
  logic [31:0] bp_a[4];
  logic [31:0] bp_b[4];

  initial begin
    int sent;
    int out_start;
    int acc_total;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_op      = MUL;
    in_a       = '0;
    in_b       = '0;
    in_product = '0;
    in_tag     = '0;

    // Reset held with a valid input present; nothing may be captured.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 1'b1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    // Release now; the MUL on the inputs is taken on the very next edge.
    rst_n = 1'b1;
    q.push_back('{32'h0000_0001, 5'h03});
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check("rst_first_lat1", o_valid, 0);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check("rst_first_valid", o_valid, 1);
    check("rst_first_res", o_res, 32'h0000_0001);

    run_one("mulhu_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFE);
    run_one("mulh_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 32'h0000_0000);
    run_one("mulhsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h06, 32'hFFFF_FFFF);
    run_one("mulh_min", 2'd1, 32'h8000_0000, 32'h0000_0002, 5'h1A, 32'hFFFF_FFFF);

    // Backpressure: four ops offered while the consumer is stalled.
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 2'(i);
      bp_a[i]  = 32'hF000_0000 + 32'(i * 7);
      bp_b[i]  = 32'h9000_0013 + 32'(i);
    end
    sent      = 0;
    out_start = n_out;
    for (int c = 0; c < 4; c++) begin
      step(sent < 4, bp_op[sent < 4 ? sent : 3], bp_a[sent < 4 ? sent : 3],
           bp_b[sent < 4 ? sent : 3], 5'(16 + sent), 1'b0);
      if (acc) sent++;
    end
    check("bp_accepts", sent, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_valid", o_valid, 1);
    check("bp_hold_op0", o_res, ref_res(bp_op[0], bp_a[0], bp_b[0]));
    for (int c = 0; c < 20 && (sent < 4 || q.size() > 0); c++) begin
      step(sent < 4, bp_op[sent < 4 ? sent : 3], bp_a[sent < 4 ? sent : 3],
           bp_b[sent < 4 ? sent : 3], 5'(16 + sent), 1'b1);
      if (acc) sent++;
    end
    check("bp_outs", n_out - out_start, 4);
    check("bp_drained", q.size(), 0);

    // Random traffic with random backpressure.
    acc_total = 0;
    for (int c = 0; c < 60000 && acc_total < 10000; c++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
           TAG_W'($urandom), $urandom_range(0, 9) < 7);
      if (acc) acc_total++;
    end
    check("rand_accepted", acc_total, 10000);
    for (int c = 0; c < 10 && q.size() > 0; c++) step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check("rand_drained", q.size(), 0);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1);
    check("idle_valid", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
